// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer controller.
// Holds the state width and the state encodings used by the sequencer,
// so the HEX debug display and any other consumer decode the same values.
package egg_timer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_SET_SEC = 3'd0,
    S_SET_MIN = 3'd1,
    S_READY   = 3'd2,
    S_RUN     = 3'd3,
    S_PAUSE   = 3'd4,
    S_ALARM   = 3'd5
  } state_t;

endpackage

// File: rtl/key_press_detect.sv
// Key press detector for one raw, active-low board key.
// Synchronises the key with two flops, then only accepts a new level once
// the synchronised key has held it for DEBOUNCE_CYC consecutive cycles.
// Accepting a low level after an accepted high produces a one-cycle pulse,
// so a held key yields exactly one press.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset (key treated as released)
//   i_key_n  raw key, active low, asynchronous to clk
//   o_press  one-cycle press pulse
module key_press_detect #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser and debounce. The counter tracks how long the synchronised
  // key has disagreed with the accepted level; any agreement (a bounce back)
  // restarts it. When it has disagreed for DEBOUNCE_CYC cycles the new level
  // is accepted, and a press is flagged if that new level is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
          r_pulse  <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_pulse;

endmodule

// File: rtl/egg_timer_sequencer.sv
// Central controller for the egg timer datapath.
// Debounces the Set and Start/Stop keys, sequences switch capture
// (seconds, then minutes), countdown, pause and alarm, and generates the
// 1 Hz decrement strobe and the alarm LED flash phase.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   set_n          raw Set key, active low
//   start_stop_n   raw Start/Stop key, active low
//   time_zero      datapath reports MM:SS == 00:00
//   sw_sec_en      capture switches into seconds (SET_SEC)
//   sw_min_en      capture switches into minutes (SET_MIN)
//   dec_pulse      registered one-cycle decrement strobe
//   in_run         high in RUN
//   flash_en       high in ALARM
//   led_phase      alarm LED pattern phase
//   state          current state encoding for debug / HEX display
module egg_timer_sequencer
  import egg_timer_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int FLASH_DIV    = 12500000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int ALARM_SECS   = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_n,
  input  logic               start_stop_n,
  input  logic               time_zero,
  output logic               sw_sec_en,
  output logic               sw_min_en,
  output logic               dec_pulse,
  output logic               in_run,
  output logic               flash_en,
  output logic               led_phase,
  output logic [STATE_W-1:0] state
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int SEC_W   = $clog2(ALARM_SECS + 1);

  state_t             r_state;
  state_t             w_next;
  logic [TICK_W-1:0]  r_tick;
  logic [FLASH_W-1:0] r_flash;
  logic [SEC_W-1:0]   r_secs;
  logic               r_led;
  logic               r_dec;
  logic               w_set_press;
  logic               w_start_press;
  logic               w_tick_tc;
  logic               w_flash_tc;
  logic               w_alarm_done;

  key_press_detect #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_set_key (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (set_n),
    .o_press (w_set_press)
  );

  key_press_detect #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_key (
    .clk     (clk),
    .reset   (reset),
    .i_key_n (start_stop_n),
    .o_press (w_start_press)
  );

  assign w_tick_tc    = (r_tick == TICK_W'(TICK_DIV - 1));
  assign w_flash_tc   = (r_flash == FLASH_W'(FLASH_DIV - 1));
  // The alarm ends on the terminal tick that completes the last second.
  assign w_alarm_done = w_tick_tc && (r_secs == SEC_W'(ALARM_SECS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SET_SEC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and Moore output decode. Set wins over Start wherever
  // both are legal. In RUN the terminal tick is resolved first, so a
  // zero-time terminal goes to ALARM even if Start lands in the same cycle.
  always_comb begin
    w_next    = r_state;
    sw_sec_en = 1'b0;
    sw_min_en = 1'b0;
    in_run    = 1'b0;
    flash_en  = 1'b0;
    case (r_state)
      S_SET_SEC: begin
        sw_sec_en = 1'b1;
        if (w_set_press) w_next = S_SET_MIN;
      end
      S_SET_MIN: begin
        sw_min_en = 1'b1;
        if (w_set_press) w_next = S_READY;
      end
      S_READY: begin
        if (w_set_press)                     w_next = S_SET_SEC;
        else if (w_start_press && !time_zero) w_next = S_RUN;
      end
      S_RUN: begin
        in_run = 1'b1;
        if (w_tick_tc && time_zero) w_next = S_ALARM;
        else if (w_start_press)     w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_set_press)        w_next = S_SET_SEC;
        else if (w_start_press) w_next = S_RUN;
      end
      S_ALARM: begin
        flash_en = 1'b1;
        if (w_set_press || w_start_press || w_alarm_done) w_next = S_SET_SEC;
      end
      default: w_next = S_SET_SEC;
    endcase
  end

  // Tick, flash and alarm-second counters plus the registered strobes.
  // The tick counter runs in RUN and ALARM, holds in PAUSE so a resume
  // finishes the partial second, and is clear elsewhere; it is therefore
  // already zero when READY hands over to RUN. Entering ALARM happens on a
  // terminal tick, so alarm seconds are aligned to the alarm entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick  <= '0;
      r_flash <= '0;
      r_secs  <= '0;
      r_led   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_dec <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_tick  <= w_tick_tc ? '0 : r_tick + TICK_W'(1);
          r_flash <= '0;
          r_secs  <= '0;
          r_led   <= 1'b0;
          r_dec   <= w_tick_tc && !time_zero;
        end
        S_PAUSE: begin
          r_flash <= '0;
          r_secs  <= '0;
          r_led   <= 1'b0;
        end
        S_ALARM: begin
          if (w_next != S_ALARM) begin
            r_tick  <= '0;
            r_flash <= '0;
            r_secs  <= '0;
            r_led   <= 1'b0;
          end else begin
            r_tick  <= w_tick_tc ? '0 : r_tick + TICK_W'(1);
            r_flash <= w_flash_tc ? '0 : r_flash + FLASH_W'(1);
            if (w_flash_tc) r_led <= ~r_led;
            if (w_tick_tc) r_secs <= r_secs + SEC_W'(1);
          end
        end
        default: begin
          r_tick  <= '0;
          r_flash <= '0;
          r_secs  <= '0;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign dec_pulse = r_dec;
  assign led_phase = r_led;
  assign state     = r_state;

endmodule

// File: doc/egg_timer_sequencer.md
Name: egg_timer_sequencer

Overview:
Central controller for the egg timer datapath. It debounces the Set and Start/Stop keys and sequences switch capture (seconds, then minutes), countdown, pause and alarm. It generates the 1 Hz decrement strobe and the alarm flash strobe. It sits between the board keys and the switch-validator, decrement-time and flash-light blocks, and replaces their ad-hoc enable and clock-divider wiring.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown second (1 Hz at CLOCK_50)
FLASH_DIV, 12500000, clk cycles per LED phase toggle in ALARM
DEBOUNCE_CYC, 500000, cycles a synchronised key must hold a level to be accepted
ALARM_SECS, 30, seconds ALARM lasts before auto-return to SET_SEC

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high; one clock only
set_n  in  1  raw Set key, active low, asynchronous to clk
start_stop_n  in  1  raw Start/Stop key, active low, asynchronous to clk
time_zero  in  1  datapath reports MM:SS == 00:00
sw_sec_en  out  1  capture switches into seconds register
sw_min_en  out  1  capture switches into minutes register
dec_pulse  out  1  one-cycle decrement strobe for the seconds/minutes chain
in_run  out  1  high while in RUN
flash_en  out  1  high while in ALARM
led_phase  out  1  alarm LED pattern phase, toggles every FLASH_DIV cycles in ALARM
state  out  3  current state encoding, for debug and HEX display

Behaviour:
- Reset (reset=1 at a clk edge): state=SET_SEC, sw_sec_en=1, all other outputs 0, all counters 0, debouncers treat keys as released.
- Key path: 2-FF synchroniser per key, then debounce. A press pulse (1 cycle) fires when the synchronised key has been low for DEBOUNCE_CYC consecutive cycles after an accepted high. A held key gives exactly one pulse. A bounce shorter than DEBOUNCE_CYC restarts the count. The state responds on the edge after the pulse.
- Outputs are decoded from state as Moore outputs: sw_sec_en=(SET_SEC), sw_min_en=(SET_MIN), in_run=(RUN), flash_en=(ALARM). dec_pulse is registered.
- SET_SEC: set_press -> SET_MIN. start press is ignored.
- SET_MIN: set_press -> READY. start press is ignored.
- READY: set_press -> SET_SEC. start_press and !time_zero -> RUN. start_press and time_zero -> stay in READY.
- RUN: the tick counter counts 0..TICK_DIV-1. At terminal count:
  - if time_zero, go to ALARM with no dec_pulse;
  - otherwise, dec_pulse=1 for exactly one cycle.
  - start_press -> PAUSE. set_press is ignored.
- RUN tie-breaks when the terminal tick and start_press land in the same cycle:
  - the tick action happens first;
  - the next state is ALARM if time_zero, otherwise PAUSE with dec_pulse still issued.
- Tick counter clears on READY->RUN, so the first dec_pulse comes exactly TICK_DIV cycles after entry. It holds its value in PAUSE, so resume continues the partial second. It clears in all other states.
- PAUSE: start_press -> RUN. set_press -> SET_SEC, abandoning the run. No dec_pulse is issued.
- ALARM:
  - flash counter counts 0..FLASH_DIV-1 and toggles led_phase at terminal count;
  - seconds counter advances on each TICK_DIV terminal;
  - any press, or seconds counter reaching ALARM_SECS -> SET_SEC, with led_phase=0 and counters cleared.
- Both presses in the same cycle: set_press takes priority wherever both are legal (READY, PAUSE). ALARM exits to SET_SEC either way.
- Reset mid-RUN or mid-ALARM: outputs reach their reset values on the next edge. No dec_pulse is issued in that cycle.
- Counter widths are sized with $clog2 of the respective divider. ALARM_SECS uses a $clog2(ALARM_SECS+1)-bit counter. Terminal compares use ==, no wrap beyond max.
- Encodings 3'd6 and 3'd7 are illegal and recover to SET_SEC on the next edge.

Decomposition:
- Shared package egg_timer_pkg holds:
  - state encodings: S_SET_SEC=0, S_SET_MIN=1, S_READY=2, S_RUN=3, S_PAUSE=4, S_ALARM=5;
  - the 3-bit state width constant.
- Sub-module key_press_detect contains the synchroniser, debounce counter and press pulse. It has parameter DEBOUNCE_CYC and is instantiated twice.

Test Plan:
(Sim parameters: TICK_DIV=10, FLASH_DIV=3, DEBOUNCE_CYC=4, ALARM_SECS=3.)
- Set sequence: reset, then three clean set_n presses -> state goes 0->1->2->0. sw_sec_en/sw_min_en track the state. Each press pulse arrives 6 cycles after set_n falls.
- Bounce rejection: set_n low 3 cycles, high 1, low 8 -> exactly one press. A 3-cycle glitch alone gives no press.
- Countdown: READY with time_zero=0, start press -> RUN. dec_pulse comes 10 cycles after RUN entry, then every 10 cycles, each 1 cycle wide. Raise time_zero -> ALARM at the next terminal, with no dec_pulse.
- Pause/resume: start press 4 cycles into a second -> PAUSE with no pulses for 50 cycles. Start again -> first dec_pulse 6 cycles after re-entry to RUN.
- Alarm: in ALARM, led_phase toggles every 3 cycles. With no key press, return to SET_SEC after 30 cycles. A set press at cycle 7 exits early, with led_phase=0.
- Edge cases:
  - start in READY with time_zero=1 -> stays READY;
  - reset asserted mid-RUN -> state=0, sw_sec_en=1, dec_pulse=0 on the next edge.
